dmem_port_arbiter: RTL

- Shares the single data-memory port between two requesters:
  - m0: the core load/store path (ALU-result address, rs2 write data).
  - m1: a loader/debug/DMA master.
- Sits between both masters and the dmem instance.
- Issues one memory command per grant and tracks a fixed-latency response with an FSM and a latency counter.
- Routes each read/write acknowledgement back to the master that was granted.

---
 rtl/dmem_port_arbiter_pkg.sv | 8 +
 rtl/dmem_port_arbiter_if.sv | 27 ++
 rtl/dmem_port_arbiter_arb_pick.sv | 22 ++
 rtl/dmem_port_arbiter.sv | 88 ++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared FSM state, owner encoding and counter width for the dmem port arbiter
package dmem_port_arbiter_pkg;
    typedef enum logic {IDLE, BUSY} arb_state_t;
    typedef logic owner_t;
    localparam owner_t OWNER_CORE = 1'b0;
    localparam owner_t OWNER_EXT  = 1'b1;
    localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: bundle of both requester ports (m0 core, m1 external) and the dmem command/response port
// slave modport = arbiter view (requests in, grants/responses out, memory command out, mem_rdata in)
// master modport = environment view (the mirror image)
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic              m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_port_arbiter_arb_pick.sv
// dmem_port_arbiter_arb_pick: combinational winner select between two requesters
// ports: req0_i/req1_i requests, last_owner_i (round-robin build only), valid_o any request, winner_o chosen owner
// DMEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority with m0 always winning
module dmem_port_arbiter_arb_pick
    import dmem_port_arbiter_pkg::*;
(
    input  logic   req0_i,
    input  logic   req1_i,
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    input  owner_t last_owner_i,
`endif
    output logic   valid_o,
    output owner_t winner_o
);
    assign valid_o = req0_i | req1_i;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // on contention the master that did not win last time goes first
    assign winner_o = (req0_i && req1_i) ? ~last_owner_i : (req1_i ? OWNER_EXT : OWNER_CORE);
`else
    assign winner_o = req0_i ? OWNER_CORE : OWNER_EXT;
`endif
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one fixed-latency data-memory port between the core (m0) and an external master (m1)
// ports: clk, rst (async, active-high), bus (dmem_port_arbiter_if.slave: both requester ports and the dmem port)
// optional macro DMEM_ARB_ROUND_ROBIN_EN: round-robin arbitration instead of fixed m0 priority
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input logic clk,
    input logic rst,
    dmem_port_arbiter_if.slave bus
);
    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("dmem_port_arbiter: MEM_LATENCY must be within 1..15");
    end

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_t            owner_q, owner_d, winner;
    logic              we_q, we_d, pick_valid, resp, issue, sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    owner_t            last_owner_q, last_owner_d;
`endif

    dmem_port_arbiter_arb_pick u_pick (
        .req0_i      (bus.m0_req),
        .req1_i      (bus.m1_req),
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        .last_owner_i(last_owner_q),
`endif
        .valid_o     (pick_valid),
        .winner_o    (winner)
    );

    // response cycle is the last count; a new command may be issued in that same cycle
    assign resp  = state_q == BUSY && cnt_q == CNT_W'(1);
    // rst gates the grant path so all outputs read 0 while reset is held
    assign issue = !rst && pick_valid && (state_q == IDLE || resp);

    assign sel_we    = winner == OWNER_EXT ? bus.m1_we    : bus.m0_we;
    assign sel_addr  = winner == OWNER_EXT ? bus.m1_addr  : bus.m0_addr;
    assign sel_wdata = winner == OWNER_EXT ? bus.m1_wdata : bus.m0_wdata;

    assign bus.mem_en    = issue;
    assign bus.mem_we    = issue & sel_we;
    assign bus.mem_addr  = issue ? sel_addr : '0;
    assign bus.mem_wdata = issue ? sel_wdata : '0;
    assign bus.m0_gnt    = issue && winner == OWNER_CORE;
    assign bus.m1_gnt    = issue && winner == OWNER_EXT;
    assign bus.m0_rvalid = resp && owner_q == OWNER_CORE;
    assign bus.m1_rvalid = resp && owner_q == OWNER_EXT;
    assign bus.m0_rdata  = (bus.m0_rvalid && !we_q) ? bus.mem_rdata : '0;
    assign bus.m1_rdata  = (bus.m1_rvalid && !we_q) ? bus.mem_rdata : '0;

    always_comb begin
        state_d = issue ? BUSY : (resp ? IDLE : state_q);
        cnt_d   = issue ? CNT_W'(MEM_LATENCY) : (state_q == BUSY ? cnt_q - 1'b1 : cnt_q);
        owner_d = issue ? winner : owner_q;
        we_d    = issue ? sel_we : we_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last_owner_d = issue ? winner : last_owner_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= OWNER_CORE;
            we_q    <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_owner_q <= OWNER_EXT;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            we_q    <= we_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end
endmodule
